// File: rtl/orb_pkg.sv
// Constants, FSM encoding and address map shared by the orbital-frame packer and reader.
// Both sides must use orb_addr so that packet/word slots line up in the frame RAM.
package orb_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 11;
  localparam int WPP    = 16;
  localparam int NPACK  = 64;
  localparam int WIDX_W = 4;
  localparam int PIDX_W = 6;
  localparam int BCNT_W = 4;

  typedef enum logic [2:0] {IDLE, FETCH, WAITD, SHIFT, NEXT, DONE} orb_state_t;

  function automatic logic [ADDR_W-1:0] orb_addr(input logic [PIDX_W-1:0] pack,
                                                  input logic [WIDX_W-1:0] word);
    return {pack, word, 1'b0};
  endfunction

endpackage

// File: rtl/orb_piso.sv
// Parallel-load, MSB-first shift register with a remaining-bit counter.
// Load wins over shift; o_msb is the bit that the next shift will retire.
module orb_piso
  import orb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_msb,
  output logic [BCNT_W-1:0] o_bitCnt
);

  logic [WORD_W-1:0] r_sh;
  logic [BCNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= BCNT_W'(WORD_W);
    end else if (i_shift) begin
      r_sh  <= {r_sh[WORD_W-2:0], 1'b0};
      r_cnt <= r_cnt - BCNT_W'(1);
    end
  end

  assign o_msb    = r_sh[WORD_W-1];
  assign o_bitCnt = r_cnt;

endmodule

// File: rtl/orb_frame_reader.sv
// Reads a full 64x16-word frame out of the packer RAM and serialises it MSB-first on bitTick.
// A word's first bit waits for the first bitTick after load; ticks outside SHIFT/DONE are dropped.
module orb_frame_reader
  import orb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_bitTick,
  input  logic [WORD_W-1:0] i_rdData,
  output logic [ADDR_W-1:0] o_rdAddr,
  output logic              o_RE,
  output logic              o_serOut,
  output logic              o_serValid,
  output logic              o_wordStb,
  output logic              o_busy,
  output logic              o_frameDone,
  output logic              o_swOut
);

  orb_state_t        r_state, w_next;
  logic [2:0]        r_sync;
  logic [PIDX_W-1:0] r_pack;
  logic [WIDX_W-1:0] r_word;
  logic [1:0]        r_wcnt;
  logic              r_serOut, r_serValid, r_wordStb, r_busy, r_frameDone, r_swOut;
  logic              w_startEdge, w_load, w_shift, w_lastWord, w_msb;
  logic [BCNT_W-1:0] w_bitCnt;

  assign w_startEdge = r_sync[1] & ~r_sync[2];
  assign w_lastWord  = (r_pack == PIDX_W'(NPACK-1)) && (r_word == WIDX_W'(WPP-1));

  orb_piso u_piso (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_data   (i_rdData),
    .o_msb    (w_msb),
    .o_bitCnt (w_bitCnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE:  if (w_startEdge) w_next = FETCH;
      FETCH: w_next = WAITD;
      WAITD: if (r_wcnt == 2'(RD_LAT-1)) begin
               w_load = 1'b1;
               w_next = SHIFT;
             end
      SHIFT: if (i_bitTick) begin
               w_shift = 1'b1;
               if (w_bitCnt == BCNT_W'(1)) w_next = NEXT;
             end
      NEXT:  w_next = w_lastWord ? DONE : FETCH;
      DONE:  if (i_bitTick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync      <= '0;
      r_pack      <= '0;
      r_word      <= '0;
      r_wcnt      <= '0;
      r_serOut    <= 1'b0;
      r_serValid  <= 1'b0;
      r_wordStb   <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_swOut     <= 1'b0;
    end else begin
      r_sync      <= {r_sync[1:0], i_start};
      r_wordStb   <= 1'b0;
      r_frameDone <= 1'b0;
      case (r_state)
        IDLE: if (w_startEdge) begin
                r_pack <= '0;
                r_word <= '0;
                r_busy <= 1'b1;
              end
        FETCH: r_wcnt <= '0;
        WAITD: r_wcnt <= r_wcnt + 2'd1;
        SHIFT: if (i_bitTick) begin
                 r_serOut   <= w_msb;
                 r_serValid <= 1'b1;
                 r_wordStb  <= (w_bitCnt == BCNT_W'(WORD_W));
               end
        NEXT: begin
                r_word <= r_word + WIDX_W'(1);
                if (r_word == WIDX_W'(WPP-1)) r_pack <= r_pack + PIDX_W'(1);
              end
        // serValid drops and the swap flag flips on the tick after the final LSB
        DONE: if (i_bitTick) begin
                r_serValid  <= 1'b0;
                r_serOut    <= 1'b0;
                r_frameDone <= 1'b1;
                r_swOut     <= ~r_swOut;
                r_busy      <= 1'b0;
              end
        default: ;
      endcase
    end
  end

  assign o_rdAddr    = orb_addr(r_pack, r_word);
  assign o_RE        = (r_state == FETCH);
  assign o_serOut    = r_serOut;
  assign o_serValid  = r_serValid;
  assign o_wordStb   = r_wordStb;
  assign o_busy      = r_busy;
  assign o_frameDone = r_frameDone;
  assign o_swOut     = r_swOut;

endmodule
